// File: rtl/rriscv_pkg.sv
// rtl/rriscv_pkg.sv - shared RISC-V op/format enums and opcode/funct field constants.
package rriscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_MUL  = 4'd1,
    OP_XOR  = 4'd2,
    OP_ADDI = 4'd3,
    OP_LW   = 4'd4,
    OP_SW   = 4'd5,
    OP_JAL  = 4'd6,
    OP_BEQ  = 4'd7,
    OP_BNE  = 4'd8
  } op_e;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_J
  } imm_fmt_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/imm_packer.sv
// rtl/imm_packer.sv - places a signed immediate into I/S/B/J instruction bit positions
// and flags values outside the format's encodable range.
import rriscv_pkg::*;

module imm_packer (
  input  imm_fmt_e          fmt_i,
  input  logic [XLEN-1:0]   imm_i,
  output logic [31:0]       imm_bits_o,
  output logic              range_err_o
);

  logic signed [XLEN-1:0] simm;
  assign simm = $signed(imm_i);

  always_comb begin
    imm_bits_o  = 32'h0;
    range_err_o = 1'b0;
    case (fmt_i)
      FMT_I: begin
        imm_bits_o  = {imm_i[11:0], 20'h0};
        range_err_o = (simm < -32'sd2048) || (simm > 32'sd2047);
      end
      FMT_S: begin
        imm_bits_o  = {imm_i[11:5], 13'h0, imm_i[4:0], 7'h0};
        range_err_o = (simm < -32'sd2048) || (simm > 32'sd2047);
      end
      FMT_B: begin
        imm_bits_o  = {imm_i[12], imm_i[10:5], 13'h0, imm_i[4:1], imm_i[11], 7'h0};
        range_err_o = (simm < -32'sd4096) || (simm > 32'sd4094) || imm_i[0];
      end
      FMT_J: begin
        imm_bits_o  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'h0};
        range_err_o = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm_i[0];
      end
      default: begin
        imm_bits_o  = 32'h0;
        range_err_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - streaming RISC-V mnemonic-to-word encoder with one-slot output.
// ENCODER_RANGE_CHECK_EN adds immediate range violations to err_o.
import rriscv_pkg::*;

module instruction_encoder #(
  parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        op_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [XLEN-1:0]   imm_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [31:0]       instr_o,
  output logic [XLEN-1:0]   addr_o,
  output logic              err_o,
  output logic [15:0]       count_o
);

  typedef enum logic {EMPTY, FULL} state_e;
  state_e state;

  imm_fmt_e    fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        illegal;
  logic [31:0] fields;
  logic [31:0] imm_bits;
  logic        range_err;
  logic [31:0] word;
  logic        word_err;
  logic        handoff;
  logic        accept;

  imm_packer u_imm_packer (
    .fmt_i       (fmt),
    .imm_i       (imm_i),
    .imm_bits_o  (imm_bits),
    .range_err_o (range_err)
  );

  always_comb begin
    fmt     = FMT_R;
    opcode  = 7'h0;
    funct3  = 3'h0;
    funct7  = F7_BASE;
    illegal = 1'b0;
    case (op_e'(op_i))
      OP_ADD:  begin fmt = FMT_R; opcode = OPC_OP;     funct3 = F3_ADD; end
      OP_MUL:  begin fmt = FMT_R; opcode = OPC_OP;     funct3 = F3_ADD; funct7 = F7_MULDIV; end
      OP_XOR:  begin fmt = FMT_R; opcode = OPC_OP;     funct3 = F3_XOR; end
      OP_ADDI: begin fmt = FMT_I; opcode = OPC_OP_IMM; funct3 = F3_ADD; end
      OP_LW:   begin fmt = FMT_I; opcode = OPC_LOAD;   funct3 = F3_LW;  end
      OP_SW:   begin fmt = FMT_S; opcode = OPC_STORE;  funct3 = F3_SW;  end
      OP_JAL:  begin fmt = FMT_J; opcode = OPC_JAL;    end
      OP_BEQ:  begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = F3_BEQ; end
      OP_BNE:  begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = F3_BNE; end
      default: illegal = 1'b1;
    endcase
  end

  // Register/funct fields only; immediate bits are OR-ed in from the packer.
  always_comb begin
    fields = 32'h0;
    case (fmt)
      FMT_R:        fields = {funct7, rs2_i, rs1_i, funct3, rd_i, opcode};
      FMT_I:        fields = {12'h0, rs1_i, funct3, rd_i, opcode};
      FMT_S, FMT_B: fields = {7'h0, rs2_i, rs1_i, funct3, 5'h0, opcode};
      FMT_J:        fields = {20'h0, rd_i, opcode};
      default:      fields = 32'h0;
    endcase
  end

  assign word = illegal ? INSTR_NOP : (fields | imm_bits);

`ifdef ENCODER_RANGE_CHECK_EN
  assign word_err = illegal || range_err;
`else
  logic unused_range;
  assign unused_range = range_err;
  assign word_err     = illegal;
`endif

  assign instr_valid_o = (state == FULL);
  assign req_ready_o   = rst_ni && !clear_i && (!instr_valid_o || instr_ready_i);
  assign handoff       = instr_valid_o && instr_ready_i;
  assign accept        = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state   <= EMPTY;
      instr_o <= 32'h0;
      err_o   <= 1'b0;
      addr_o  <= BASE_ADDR;
      count_o <= 16'h0;
    end else begin
      if (handoff) begin
        addr_o <= addr_o + XLEN'(4);
        if (count_o != 16'hFFFF) count_o <= count_o + 16'd1;
      end
      if (accept) begin
        state   <= FULL;
        instr_o <= word;
        err_o   <= word_err;
      end else if (handoff) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - directed self-checking bench for instruction_encoder.
`timescale 1ns/1ps
import rriscv_pkg::*;

module tb_instruction_encoder;

  localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef ENCODER_RANGE_CHECK_EN
  localparam logic [31:0] JAL3_ERR = 32'd1;
`else
  localparam logic [31:0] JAL3_ERR = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  op_i;
  logic [4:0]  rd_i, rs1_i, rs2_i;
  logic [31:0] imm_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] addr_o;
  logic        err_o;
  logic [15:0] count_o;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_encoder #(.BASE_ADDR(BASE)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .op_i          (op_i),
    .rd_i          (rd_i),
    .rs1_i         (rs1_i),
    .rs2_i         (rs2_i),
    .imm_i         (imm_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .addr_o        (addr_o),
    .err_o         (err_o),
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
    req_valid_i = 1'b1;
    op_i  = op;
    rd_i  = rd;
    rs1_i = rs1;
    rs2_i = rs2;
    imm_i = imm;
  endtask

  logic [3:0]  t_op  [4];
  logic [4:0]  t_rd  [4];
  logic [4:0]  t_rs1 [4];
  logic [4:0]  t_rs2 [4];
  logic [31:0] t_imm [4];
  logic [31:0] t_exp [4];

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; req_valid_i = 1'b0; instr_ready_i = 1'b0;
    op_i = 4'd0; rd_i = 5'd0; rs1_i = 5'd0; rs2_i = 5'd0; imm_i = 32'h0;
    tick();
    tick();
    chk("ready_in_reset", 32'(req_ready_o), 32'd0);
    rst_ni = 1'b1;
    #1;
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_addr", addr_o, BASE);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd1);

    // ADD x3,x1,x2
    instr_ready_i = 1'b1;
    set_req(OP_ADD, 5'd3, 5'd1, 5'd2, 32'h0);
    tick();
    req_valid_i = 1'b0;
    chk("add_valid", 32'(instr_valid_o), 32'd1);
    chk("add_instr", instr_o, 32'h002081B3);
    chk("add_addr", addr_o, BASE);
    chk("add_err", 32'(err_o), 32'd0);
    tick();
    chk("add_done_valid", 32'(instr_valid_o), 32'd0);
    chk("add_done_count", 32'(count_o), 32'd1);
    chk("add_done_addr", addr_o, BASE + 32'd4);

    // clear while empty; a request during clear is refused
    clear_i = 1'b1;
    set_req(OP_ADD, 5'd3, 5'd1, 5'd2, 32'h0);
    #1;
    chk("ready_in_clear", 32'(req_ready_o), 32'd0);
    tick();
    clear_i = 1'b0;
    req_valid_i = 1'b0;
    chk("clear_valid", 32'(instr_valid_o), 32'd0);
    chk("clear_addr", addr_o, BASE);
    chk("clear_count", 32'(count_o), 32'd0);

    // ADDI x1,x0,-1 then SW x2,8(x1) back-to-back
    set_req(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    tick();
    chk("addi_instr", instr_o, 32'hFFF00093);
    chk("addi_addr", addr_o, BASE);
    set_req(OP_SW, 5'd0, 5'd1, 5'd2, 32'd8);
    tick();
    req_valid_i = 1'b0;
    chk("sw_valid", 32'(instr_valid_o), 32'd1);
    chk("sw_instr", instr_o, 32'h0020A423);
    chk("sw_addr", addr_o, BASE + 32'd4);
    chk("sw_count", 32'(count_o), 32'd1);
    tick();
    chk("b2b_count", 32'(count_o), 32'd2);
    chk("b2b_addr", addr_o, BASE + 32'd8);

    // BEQ x1,x2,-4 with the consumer stalled for 3 cycles
    instr_ready_i = 1'b0;
    set_req(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
    tick();
    req_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("beq_hold_valid", 32'(instr_valid_o), 32'd1);
      chk("beq_hold_instr", instr_o, 32'hFE208EE3);
      chk("beq_hold_addr", addr_o, BASE + 32'd8);
      chk("beq_hold_ready", 32'(req_ready_o), 32'd0);
      tick();
    end
    instr_ready_i = 1'b1;
    #1;
    chk("beq_release_ready", 32'(req_ready_o), 32'd1);
    tick();
    chk("beq_done_valid", 32'(instr_valid_o), 32'd0);
    chk("beq_done_count", 32'(count_o), 32'd3);

    // JAL x1,8 then JAL x0,3 (odd offset)
    set_req(OP_JAL, 5'd1, 5'd0, 5'd0, 32'd8);
    tick();
    chk("jal_instr", instr_o, 32'h008000EF);
    chk("jal_err", 32'(err_o), 32'd0);
    set_req(OP_JAL, 5'd0, 5'd0, 5'd0, 32'd3);
    tick();
    chk("jal3_instr", instr_o, 32'h0020006F);
    chk("jal3_err", 32'(err_o), JAL3_ERR);

    // illegal op 15
    set_req(4'd15, 5'd1, 5'd2, 5'd3, 32'h123);
    tick();
    req_valid_i = 1'b0;
    chk("illegal_instr", instr_o, 32'h00000013);
    chk("illegal_err", 32'(err_o), 32'd1);
    chk("illegal_addr", addr_o, BASE + 32'h14);
    tick();
    chk("illegal_done_addr", addr_o, BASE + 32'h18);
    chk("illegal_done_count", 32'(count_o), 32'd6);

    // table: XOR x5,x6,x7 / MUL x1,x2,x3 / LW x5,-4(x2) / BNE x3,x4,16
    t_op[0] = OP_XOR; t_rd[0] = 5'd5; t_rs1[0] = 5'd6; t_rs2[0] = 5'd7; t_imm[0] = 32'h0;         t_exp[0] = 32'h007342B3;
    t_op[1] = OP_MUL; t_rd[1] = 5'd1; t_rs1[1] = 5'd2; t_rs2[1] = 5'd3; t_imm[1] = 32'h0;         t_exp[1] = 32'h023100B3;
    t_op[2] = OP_LW;  t_rd[2] = 5'd5; t_rs1[2] = 5'd2; t_rs2[2] = 5'd0; t_imm[2] = 32'hFFFF_FFFC; t_exp[2] = 32'hFFC12283;
    t_op[3] = OP_BNE; t_rd[3] = 5'd0; t_rs1[3] = 5'd3; t_rs2[3] = 5'd4; t_imm[3] = 32'd16;        t_exp[3] = 32'h00419863;
    for (int i = 0; i < 4; i++) begin
      set_req(t_op[i], t_rd[i], t_rs1[i], t_rs2[i], t_imm[i]);
      tick();
      chk("table_instr", instr_o, t_exp[i]);
      chk("table_err", 32'(err_o), 32'd0);
      chk("table_addr", addr_o, BASE + 32'h18 + 32'(i * 4));
    end
    req_valid_i = 1'b0;
    tick();
    chk("table_count", 32'(count_o), 32'd10);

    // clear while FULL discards the word
    instr_ready_i = 1'b0;
    set_req(OP_ADD, 5'd3, 5'd1, 5'd2, 32'h0);
    tick();
    req_valid_i = 1'b0;
    chk("pre_clear_valid", 32'(instr_valid_o), 32'd1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clr_full_valid", 32'(instr_valid_o), 32'd0);
    chk("clr_full_instr", instr_o, 32'h0);
    chk("clr_full_addr", addr_o, BASE);
    chk("clr_full_count", 32'(count_o), 32'd0);
    instr_ready_i = 1'b1;
    tick();
    chk("clr_full_no_handoff", 32'(count_o), 32'd0);

    // reset while FULL discards the word
    instr_ready_i = 1'b0;
    set_req(OP_XOR, 5'd5, 5'd6, 5'd7, 32'h0);
    tick();
    req_valid_i = 1'b0;
    tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    chk("rst_full_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_full_addr", addr_o, BASE);
    chk("rst_full_count", 32'(count_o), 32'd0);
    instr_ready_i = 1'b1;
    tick();
    chk("rst_full_no_handoff", 32'(count_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
